// File: rtl/a_trace_readback_framer_pkg.sv
// Shared definitions for the trace readback framer: FSM encoding, header layout and builder.
package a_trace_readback_framer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2,
        CKS  = 2'd3
    } state_t;

    localparam logic [3:0] HDR_TAG_DEF = 4'hA;

    // Header word layout: {tag[15:12], carte[11], fpga[10:7], id[6:3], seq[2:0]}
    localparam int HDR_TAG_LSB   = 12;
    localparam int HDR_CARTE_LSB = 11;
    localparam int HDR_FPGA_LSB  = 7;
    localparam int HDR_ID_LSB    = 3;

    function automatic logic [15:0] make_hdr(input logic [3:0] tag, input logic carte,
                                             input logic [3:0] fpga, input logic [3:0] id,
                                             input logic [2:0] seq);
        logic [15:0] h;
        h                       = '0;
        h[HDR_TAG_LSB +: 4]     = tag;
        h[HDR_CARTE_LSB]        = carte;
        h[HDR_FPGA_LSB +: 4]    = fpga;
        h[HDR_ID_LSB +: 4]      = id;
        h[2:0]                  = seq;
        return h;
    endfunction

endpackage

// File: rtl/a_trace_readback_framer_fifo.sv
// First-word-fall-through synchronous FIFO buffering readback words ahead of the framer.
module a_trace_fifo #(
    parameter int AW = 3,
    parameter int W  = 16
) (
    input  logic         clk_ref,
    input  logic         rst,
    input  logic         clr,
    input  logic         wr,
    input  logic [W-1:0] din,
    input  logic         rd,
    output logic [W-1:0] dout,
    output logic [AW:0]  count,
    output logic         full,
    output logic         empty
);
    localparam int DEPTH = 2**AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          do_wr, do_rd;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign do_wr = wr && !full;
    assign do_rd = rd && !empty;
    assign dout  = mem[rptr];

    always_ff @(posedge clk_ref) begin
        if (do_wr) mem[wptr] <= din;
    end

    always_ff @(posedge clk_ref or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) wptr <= wptr + 1'b1;
            if (do_rd) rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end

endmodule

// File: rtl/a_trace_readback_framer.sv
// Frames trace readback words as header / FRAME_WORDS payload / XOR checksum on a valid-ready link.
module a_trace_readback_framer
    import a_trace_readback_framer_pkg::*;
#(
    parameter int         FRAME_WORDS = 16,
    parameter int         FIFO_AW     = 3,
    parameter int         BUSY_MARGIN = 2,
    parameter logic [3:0] HDR_TAG     = HDR_TAG_DEF
) (
    input  logic        clk_ref,
    input  logic        rst,
    input  logic        soft_init_i,
    input  logic        carte_i,
    input  logic [3:0]  fpga_i,
    input  logic [3:0]  id_i,
    input  logic [15:0] trce_data_i,
    input  logic        trce_dv_i,
    input  logic        flush_i,
    output logic        busi_o,
    output logic [15:0] tx_data_o,
    output logic        tx_dv_o,
    input  logic        tx_ready_i,
    output logic        ovf_o,
    output logic        frame_done_o
);
    localparam int             CW     = FIFO_AW + 1;
    localparam logic [CW-1:0]  DEPTH  = CW'(2**FIFO_AW);
    localparam logic [CW-1:0]  MARGIN = CW'(BUSY_MARGIN);
    localparam logic [7:0]     LAST   = 8'(FRAME_WORDS - 1);

    state_t        state, state_n;
    logic [15:0]   head, data_n, xsum, xsum_n;
    logic [CW-1:0] count, count_next;
    logic [7:0]    cnt, cnt_n;
    logic [2:0]    seq, seq_n;
    logic          push, pop, full, empty, accept, load;
    logic          dv_n, flush_q, flush_n, done_n;

    assign push       = trce_dv_i && !full;
    assign accept     = tx_dv_o && tx_ready_i;
    assign count_next = count + CW'(push) - CW'(pop);

    a_trace_fifo #(.AW(FIFO_AW), .W(16)) u_fifo (
        .clk_ref (clk_ref),
        .rst     (rst),
        .clr     (soft_init_i),
        .wr      (push),
        .din     (trce_data_i),
        .rd      (pop),
        .dout    (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    // The output register holds the word in flight; a payload word leaves the FIFO when it is loaded.
    always_comb begin
        state_n = state;
        data_n  = tx_data_o;
        dv_n    = tx_dv_o;
        xsum_n  = xsum;
        cnt_n   = cnt;
        seq_n   = seq;
        done_n  = 1'b0;
        pop     = 1'b0;
        load    = 1'b0;
        flush_n = flush_q || (flush_i && (state != IDLE || count != '0));
        case (state)
            IDLE: if (count != '0 || flush_q) begin
                state_n = HDR;
                dv_n    = 1'b1;
                data_n  = make_hdr(HDR_TAG, carte_i, fpga_i, id_i, seq);
            end
            HDR: if (accept) begin
                xsum_n  = tx_data_o;
                cnt_n   = '0;
                state_n = PAY;
                load    = 1'b1;
            end
            PAY: if (accept) begin
                xsum_n = xsum ^ tx_data_o;
                cnt_n  = cnt + 8'd1;
                if (cnt == LAST) begin
                    state_n = CKS;
                    dv_n    = 1'b1;
                    data_n  = xsum ^ tx_data_o;
                end else begin
                    load = 1'b1;
                end
            end else if (!tx_dv_o) begin
                load = 1'b1;
            end
            CKS: if (accept) begin
                state_n = IDLE;
                dv_n    = 1'b0;
                data_n  = '0;
                seq_n   = seq + 3'd1;
                done_n  = 1'b1;
                flush_n = 1'b0;
            end
        endcase
        // Real data always wins over padding, so a flush only pads once the FIFO has drained.
        if (load) begin
            if (!empty) begin
                pop    = 1'b1;
                dv_n   = 1'b1;
                data_n = head;
            end else if (flush_n) begin
                dv_n   = 1'b1;
                data_n = '0;
            end else begin
                dv_n   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_ref or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            tx_dv_o      <= 1'b0;
            tx_data_o    <= '0;
            xsum         <= '0;
            cnt          <= '0;
            seq          <= '0;
            flush_q      <= 1'b0;
            frame_done_o <= 1'b0;
            busi_o       <= 1'b0;
            ovf_o        <= 1'b0;
        end else if (soft_init_i) begin
            state        <= IDLE;
            tx_dv_o      <= 1'b0;
            tx_data_o    <= '0;
            xsum         <= '0;
            cnt          <= '0;
            seq          <= '0;
            flush_q      <= 1'b0;
            frame_done_o <= 1'b0;
            busi_o       <= 1'b0;
            ovf_o        <= 1'b0;
        end else begin
            state        <= state_n;
            tx_dv_o      <= dv_n;
            tx_data_o    <= data_n;
            xsum         <= xsum_n;
            cnt          <= cnt_n;
            seq          <= seq_n;
            flush_q      <= flush_n;
            frame_done_o <= done_n;
            busi_o       <= (DEPTH - count_next) <= MARGIN;
            ovf_o        <= ovf_o || (trce_dv_i && full);
        end
    end

endmodule
